// File: rtl/noc_arb_pkg.sv
// Shared types and constants for the NoC injection-port arbiter.
// Optional stall timeout is enabled by defining NOC_ARB_TIMEOUT_EN.
package noc_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_BURST = 2'd1,
        ST_CLOSE = 2'd2
    } arb_state_e;

    // Stall counter width; TIMEOUT_CYC must stay below 2**TMO_CNT_W.
    localparam int unsigned TMO_CNT_W = 16;

endpackage

// File: rtl/noc_inj_arbiter_if.sv
// Requester-side and leaf-side handshake bundle of the injection arbiter.
// master = requesters + leaf (bench side), slave = the arbiter.
interface noc_inj_arbiter_if #(
    parameter int NR_REQ = 4,
    parameter int D_W    = 38,
    parameter int A_W    = 3
);
    logic [NR_REQ-1:0]          req_valid;
    logic [NR_REQ-1:0][D_W-1:0] req_data;
    logic [NR_REQ-1:0]          req_last;
    logic [NR_REQ-1:0][A_W-1:0] req_addr;
    logic [NR_REQ-1:0]          req_ready;
    logic                       noc_valid;
    logic [D_W-1:0]             noc_data;
    logic                       noc_last;
    logic [A_W-1:0]             noc_addr;
    logic                       noc_credit_gnt;
    logic                       timeout_err;

    modport master (
        output req_valid, req_data, req_last, req_addr, noc_credit_gnt,
        input  req_ready, noc_valid, noc_data, noc_last, noc_addr, timeout_err
    );

    modport slave (
        input  req_valid, req_data, req_last, req_addr, noc_credit_gnt,
        output req_ready, noc_valid, noc_data, noc_last, noc_addr, timeout_err
    );
endinterface

// File: rtl/noc_rr_arbiter.sv
// Combinational rotating-priority pick: first asserted request at or after
// i_ptr, wrapping modulo NR_REQ.
module noc_rr_arbiter #(
    parameter  int NR_REQ = 4,
    localparam int IDX_W  = $clog2(NR_REQ)
) (
    input  logic [NR_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]  i_ptr,
    output logic [IDX_W-1:0]  o_idx,
    output logic              o_any
);

    int               w_sum;
    logic [IDX_W-1:0] w_pos;

    // Scan from the farthest offset back to the pointer so the nearest hit wins.
    always_comb begin
        w_sum = 0;
        w_pos = {IDX_W{1'b0}};
        o_idx = {IDX_W{1'b0}};
        o_any = 1'b0;
        for (int off = NR_REQ - 1; off >= 0; off--) begin
            w_sum = (int'(i_ptr) + off) % NR_REQ;
            w_pos = IDX_W'(w_sum);
            if (i_req[w_pos]) begin
                o_idx = w_pos;
                o_any = 1'b1;
            end else begin
                o_idx = o_idx;
                o_any = o_any;
            end
        end
    end

endmodule

// File: rtl/noc_inj_arbiter.sv
// Packet-atomic round-robin arbiter sharing one NoC leaf injection port.
// Define NOC_ARB_TIMEOUT_EN to force-close packets whose owner stalls.
module noc_inj_arbiter
    import noc_arb_pkg::*;
#(
    parameter int NR_REQ      = 4,
    parameter int D_W         = 38,
    parameter int A_W         = 3,
    parameter int TIMEOUT_CYC = 64
) (
    input  logic               clk,
    input  logic               rst,
    noc_inj_arbiter_if.slave   bus
);

    localparam int IDX_W = $clog2(NR_REQ);

    typedef struct packed {
        logic [D_W-1:0] data;
        logic           last;
        logic [A_W-1:0] addr;
    } flit_t;

    if (NR_REQ < 2 || TIMEOUT_CYC < 2 || TIMEOUT_CYC >= (1 << TMO_CNT_W)) begin : g_bad_cfg
        $error("noc_inj_arbiter: illegal NR_REQ/TIMEOUT_CYC");
    end

    arb_state_e        r_state,  w_state_nxt;
    logic [IDX_W-1:0]  r_grant,  w_grant_nxt;
    logic [IDX_W-1:0]  r_rr_ptr, w_rr_ptr_nxt;
    logic              r_head,   w_head_nxt;
    flit_t             r_out,    w_out_nxt;
    logic              r_out_vld, w_out_vld_nxt;

    logic [NR_REQ-1:0] w_req_ready;
    logic [IDX_W-1:0]  w_pick_idx;
    logic              w_pick_any;
    logic [IDX_W-1:0]  w_grant_inc;
    logic              w_out_free;
    logic              w_grant_valid;
    logic              w_accept;
    logic              w_close_load;
    logic              w_tmo_hit;

    noc_rr_arbiter #(.NR_REQ(NR_REQ)) u_rr (
        .i_req (bus.req_valid),
        .i_ptr (r_rr_ptr),
        .o_idx (w_pick_idx),
        .o_any (w_pick_any)
    );

    assign w_grant_inc   = (r_grant == IDX_W'(NR_REQ - 1)) ? {IDX_W{1'b0}} : r_grant + IDX_W'(1);
    assign w_out_free    = !r_out_vld || bus.noc_credit_gnt;
    assign w_grant_valid = bus.req_valid[r_grant];
    assign w_accept      = (r_state == ST_BURST) && w_grant_valid && w_out_free;

`ifdef NOC_ARB_TIMEOUT_EN
    logic [TMO_CNT_W-1:0] r_tmo_cnt;
    logic                 r_tmo_err;

    assign w_tmo_hit = (r_state == ST_BURST) && !w_grant_valid &&
                       (r_tmo_cnt == TMO_CNT_W'(TIMEOUT_CYC - 1));

    // Stall counter: counts owner-idle cycles inside a packet.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_cnt <= {TMO_CNT_W{1'b0}};
        end else if (r_state != ST_BURST || w_accept) begin
            r_tmo_cnt <= {TMO_CNT_W{1'b0}};
        end else if (!w_grant_valid) begin
            r_tmo_cnt <= r_tmo_cnt + TMO_CNT_W'(1);
        end else begin
            r_tmo_cnt <= r_tmo_cnt;
        end
    end

    // Error pulse coincides with the forced tail flit on the leaf.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_tmo_err <= 1'b0;
        end else begin
            r_tmo_err <= w_close_load;
        end
    end

    assign bus.timeout_err = r_tmo_err;
`else
    assign w_tmo_hit       = 1'b0;
    assign bus.timeout_err = 1'b0;
`endif

    // Next-state, grant handshake and output-register load.
    always_comb begin
        w_state_nxt   = r_state;
        w_grant_nxt   = r_grant;
        w_rr_ptr_nxt  = r_rr_ptr;
        w_head_nxt    = r_head;
        w_out_nxt     = r_out;
        w_out_vld_nxt = r_out_vld;
        w_req_ready   = {NR_REQ{1'b0}};
        w_close_load  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_pick_any) begin
                    w_state_nxt = ST_BURST;
                    w_grant_nxt = w_pick_idx;
                    w_head_nxt  = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_BURST: begin
                w_req_ready[r_grant] = w_out_free;
                if (w_accept && bus.req_last[r_grant]) begin
                    w_state_nxt  = ST_IDLE;
                    w_rr_ptr_nxt = w_grant_inc;
                end else if (w_tmo_hit) begin
                    w_state_nxt = ST_CLOSE;
                end else begin
                    w_state_nxt = ST_BURST;
                end
            end
`ifdef NOC_ARB_TIMEOUT_EN
            ST_CLOSE: begin
                if (w_out_free) begin
                    w_close_load = 1'b1;
                    w_rr_ptr_nxt = w_grant_inc;
                    w_state_nxt  = ST_IDLE;
                end else begin
                    w_state_nxt = ST_CLOSE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // The route address is captured once per packet, on its head flit.
        if (w_accept) begin
            w_out_vld_nxt  = 1'b1;
            w_out_nxt.data = bus.req_data[r_grant];
            w_out_nxt.last = bus.req_last[r_grant];
            w_out_nxt.addr = r_head ? bus.req_addr[r_grant] : r_out.addr;
            w_head_nxt     = 1'b0;
        end else if (w_close_load) begin
            w_out_vld_nxt  = 1'b1;
            w_out_nxt.data = {D_W{1'b0}};
            w_out_nxt.last = 1'b1;
            w_out_nxt.addr = r_out.addr;
        end else if (bus.noc_credit_gnt) begin
            w_out_vld_nxt = 1'b0;
        end else begin
            w_out_vld_nxt = r_out_vld;
        end
    end

    // State, arbitration and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_IDLE;
            r_grant   <= {IDX_W{1'b0}};
            r_rr_ptr  <= {IDX_W{1'b0}};
            r_head    <= 1'b0;
            r_out     <= '{data: {D_W{1'b0}}, last: 1'b0, addr: {A_W{1'b0}}};
            r_out_vld <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_grant   <= w_grant_nxt;
            r_rr_ptr  <= w_rr_ptr_nxt;
            r_head    <= w_head_nxt;
            r_out     <= w_out_nxt;
            r_out_vld <= w_out_vld_nxt;
        end
    end

    assign bus.req_ready = w_req_ready;
    assign bus.noc_valid = r_out_vld;
    assign bus.noc_data  = r_out.data;
    assign bus.noc_last  = r_out.last;
    assign bus.noc_addr  = r_out.addr;

endmodule
